// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder
// Fetches 8-bit grayscale pixels of one frame from frame memory through a
// credit-limited prefetch FIFO and hands out one RGB444 pixel per display
// request. An optional binarization mode renders pixels as pure black/white.
//
// Ports
//   clk, reset            pixel clock, asynchronous active-high reset
//   frame_start           pulse: (re)start fetching a frame at address 0
//   pix_req               display consumes one pixel this cycle
//   bin_en, threshold     binarize against threshold (unsigned, gray >= thr)
//   mem_rd_en, mem_addr   read request and its row-major address
//   mem_rd_ready          memory accepts the request this cycle
//   mem_rdata, mem_rvalid in-order read return
//   red, green, blue      registered pixel colour
//   pix_valid             colour carries a real pixel
//   underflow             sticky: a request found the FIFO empty this frame
//   frame_done            pulse alongside the last pixel of the frame
//
// state | meaning
// IDLE  | no frame in progress; requests and returns are ignored
// FETCH | issuing reads, delivering pixels
// DRAIN | all reads issued, delivering the remaining pixels
module vga_pixel_feeder #(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int ADDR_W     = 21,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_req,
  input  logic              bin_en,
  input  logic [7:0]        threshold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ready,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              pix_valid,
  output logic              underflow,
  output logic              frame_done
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [FC_W:0]    DEPTH_C = (FC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_q, issue_d, consumed_q, consumed_d;
  logic [ADDR_W-1:0] addr_d;
  logic [FC_W-1:0]   fifo_count_q, fifo_count_d;
  logic [FC_W-1:0]   outstanding_q, outstanding_d;
  logic [FC_W-1:0]   discard_q, discard_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [7:0]        gray;
  logic              accept, ret, active, consume, fifo_empty;
  logic              pop, push, last_consume, rd_en_d;
  logic [3:0]        color_d;
  logic              pix_valid_d, underflow_d, frame_done_d;

  always_comb begin
    state_d       = state_q;
    issue_d       = issue_q;
    consumed_d    = consumed_q;
    addr_d        = mem_addr;
    fifo_count_d  = fifo_count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    accept       = mem_rd_en & mem_rd_ready;
    // a return with nothing in flight (e.g. after reset) is stray and ignored
    ret          = mem_rvalid & (outstanding_q != '0);
    active       = (state_q != IDLE);
    consume      = pix_req & active & ~frame_start;
    fifo_empty   = (fifo_count_q == '0);
    pop          = consume & ~fifo_empty;
    push         = mem_rvalid & (discard_q == '0) & active & ~frame_start;
    last_consume = consume & (consumed_q == LAST);
    gray         = fifo_mem[rd_ptr_q];

    case ({accept, ret})
      2'b10:   outstanding_d = outstanding_q + FC_W'(1);
      2'b01:   outstanding_d = outstanding_q - FC_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (frame_start) begin
      state_d      = FETCH;
      issue_d      = '0;
      consumed_d   = '0;
      addr_d       = '0;
      fifo_count_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      // everything still in flight after this edge belongs to the old frame
      discard_d    = outstanding_d;
    end else begin
      if (mem_rvalid && discard_q != '0) discard_d = discard_q - FC_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + FC_W'(1);
        2'b01:   fifo_count_d = fifo_count_q - FC_W'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
      if (accept) begin
        issue_d = issue_q + CNT_W'(1);
        // the address stops at the last pixel instead of running past the frame
        if (issue_q == LAST) state_d = DRAIN;
        else                 addr_d  = mem_addr + ADDR_W'(1);
      end
      if (consume) consumed_d = consumed_q + CNT_W'(1);
      // display position reached the end even if reads are still pending
      if (last_consume) state_d = IDLE;
    end

    // registered request: credit is judged on the values after this edge
    rd_en_d = (state_d == FETCH) &&
              (({1'b0, fifo_count_d} + {1'b0, outstanding_d}) < DEPTH_C);

    color_d     = 4'h0;
    pix_valid_d = pop;
    if (pop) begin
      if (bin_en) color_d = (gray >= threshold) ? 4'hF : 4'h0;
      else        color_d = gray[7:4];
    end
    underflow_d  = frame_start ? 1'b0 : (underflow | (consume & fifo_empty));
    frame_done_d = last_consume;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      issue_q       <= '0;
      consumed_q    <= '0;
      mem_addr      <= '0;
      mem_rd_en     <= 1'b0;
      fifo_count_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      red           <= 4'h0;
      green         <= 4'h0;
      blue          <= 4'h0;
      pix_valid     <= 1'b0;
      underflow     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_q       <= issue_d;
      consumed_q    <= consumed_d;
      mem_addr      <= addr_d;
      mem_rd_en     <= rd_en_d;
      fifo_count_q  <= fifo_count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      red           <= color_d;
      green         <= color_d;
      blue          <= color_d;
      pix_valid     <= pix_valid_d;
      underflow     <= underflow_d;
      frame_done    <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
module tb_vga_pixel_feeder;

  localparam int NPIX = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, pix_req, bin_en;
  logic [7:0]  threshold;
  logic        mem_rd_en;
  logic [20:0] mem_addr;
  logic        mem_rd_ready;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  red, green, blue;
  logic        pix_valid, underflow, frame_done;

  vga_pixel_feeder #(.H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(21), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_req(pix_req),
    .bin_en(bin_en), .threshold(threshold), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_ready(mem_rd_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .underflow(underflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // memory model: in-order returns, configurable latency and ready pattern
  typedef struct {
    logic [20:0] addr;
    int          due;
  } req_t;

  req_t       q[$];
  logic [7:0] img [NPIX];
  int         cyc = 0;
  int         lat = 1;
  bit         toggle = 1'b0;
  int         acc_cnt = 0;
  int         pv_cnt = 0;
  bit         credit_chk = 1'b0;
  int         credit_viol = 0;
  logic [20:0] addr_max = '0;

  always @(negedge clk) begin
    cyc++;
    if (pix_valid) pv_cnt++;
    mem_rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
    if (mem_rd_en && mem_rd_ready) begin
      q.push_back('{mem_addr, cyc + lat});
      if (!frame_start) acc_cnt++;
      if (mem_addr > addr_max) addr_max = mem_addr;
    end
    if (frame_start) begin
      acc_cnt = 0;
      pv_cnt  = 0;
    end
    if (credit_chk && (acc_cnt - pv_cnt > 16)) credit_viol++;
    if (q.size() > 0 && q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = img[q[0].addr[4:0]];
      void'(q.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
    end
  end

  typedef struct {
    logic [7:0] gray;
    logic       bin;
    logic [7:0] thr;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;
    logic       prev_req;
    int         k;

    vecs[0]  = '{8'h00, 1'b0, 8'h00, 4'h0};
    vecs[1]  = '{8'hFF, 1'b0, 8'h00, 4'hF};
    vecs[2]  = '{8'h7F, 1'b0, 8'h00, 4'h7};
    vecs[3]  = '{8'h80, 1'b0, 8'h00, 4'h8};
    vecs[4]  = '{8'h3C, 1'b0, 8'h00, 4'h3};
    vecs[5]  = '{8'hA5, 1'b0, 8'h00, 4'hA};
    vecs[6]  = '{8'h7F, 1'b1, 8'h80, 4'h0};
    vecs[7]  = '{8'h80, 1'b1, 8'h80, 4'hF};
    vecs[8]  = '{8'h00, 1'b1, 8'h00, 4'hF};
    vecs[9]  = '{8'hFF, 1'b1, 8'hFF, 4'hF};
    vecs[10] = '{8'hFE, 1'b1, 8'hFF, 4'h0};
    vecs[11] = '{8'h10, 1'b1, 8'h0F, 4'hF};
    vecs[12] = '{8'h0F, 1'b1, 8'h10, 4'h0};
    vecs[13] = '{8'hC3, 1'b1, 8'h40, 4'hF};
    vecs[14] = '{8'h40, 1'b0, 8'hFF, 4'h4};
    vecs[15] = '{8'hEE, 1'b1, 8'hEF, 4'h0};

    reset = 1'b1; frame_start = 1'b0; pix_req = 1'b0; bin_en = 1'b0;
    threshold = 8'h00;
    mem_rd_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_frame_done", frame_done, 0);

    // idle requests produce nothing and no underflow
    pix_req = 1'b1; step(); pix_req = 1'b0;
    chk("idle_pix_valid", pix_valid, 0);
    chk("idle_underflow", underflow, 0);

    // conversion table over a full frame, single-cycle memory
    for (int i = 0; i < NPIX; i++) img[i] = vecs[i % 16].gray;
    lat = 1; toggle = 1'b0; addr_max = '0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (20) step();
    for (int i = 0; i < NPIX; i++) begin
      pix_req = 1'b1; bin_en = vecs[i % 16].bin; threshold = vecs[i % 16].thr;
      step();
      e = vecs[i % 16].exp;
      chk($sformatf("t2_rgb_%0d", i), {red, green, blue}, {e, e, e});
      chk($sformatf("t2_valid_%0d", i), pix_valid, 1);
      chk($sformatf("t2_done_%0d", i), frame_done, (i == NPIX - 1) ? 1 : 0);
    end
    pix_req = 1'b0; bin_en = 1'b0; threshold = 8'h00;
    step();
    chk("t2_done_clear", frame_done, 0);
    chk("t2_no_req_valid", pix_valid, 0);
    chk("t2_no_req_rgb", {red, green, blue}, 0);
    chk("t2_underflow", underflow, 0);
    chk("t2_rd_en_idle", mem_rd_en, 0);
    chk("t2_addr_max", addr_max, NPIX - 1);

    // credit limit: ready toggling, latency 8, FIFO filled before any request
    for (int i = 0; i < NPIX; i++) img[i] = 8'((i * 7 + 3) % 256);
    lat = 8; toggle = 1'b1; credit_chk = 1'b1; credit_viol = 0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (80) step();
    chk("t3_accepted_full", acc_cnt, 16);
    chk("t3_rd_en_full", mem_rd_en, 0);
    k = 0;
    prev_req = 1'b0;
    for (int n = 0; n < 400 && k < NPIX; n++) begin
      pix_req = (n % 3 == 0);
      prev_req = pix_req;
      step();
      if (prev_req) begin
        e = img[k][7:4];
        chk($sformatf("t3_valid_%0d", k), pix_valid, 1);
        chk($sformatf("t3_rgb_%0d", k), {red, green, blue}, {e, e, e});
        k++;
        chk($sformatf("t3_done_%0d", k), frame_done, (k == NPIX) ? 1 : 0);
      end else begin
        chk("t3_gap_valid", pix_valid, 0);
      end
    end
    pix_req = 1'b0;
    chk("t3_all_delivered", k, NPIX);
    chk("t3_credit", credit_viol, 0);
    chk("t3_underflow", underflow, 0);
    credit_chk = 1'b0; toggle = 1'b0;
    repeat (5) step();

    // mid-frame restart with 5 reads in flight, coincident with pix_req
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int n = 0; n < 30 && q.size() < 5; n++) step();
    chk("t4_inflight", q.size(), 5);
    frame_start = 1'b1; pix_req = 1'b1;
    step();
    frame_start = 1'b0;
    chk("t4_fs_valid", pix_valid, 0);
    chk("t4_fs_rgb", {red, green, blue}, 0);
    chk("t4_fs_underflow", underflow, 0);
    chk("t4_addr_restart", mem_addr, 0);
    step();
    pix_req = 1'b0;
    chk("t4_empty_valid", pix_valid, 0);
    chk("t4_underflow_set", underflow, 1);
    repeat (40) step();
    chk("t4_underflow_sticky", underflow, 1);
    for (int i = 0; i < NPIX - 1; i++) begin
      pix_req = 1'b1;
      step();
      e = img[i][7:4];
      chk($sformatf("t4_valid_%0d", i), pix_valid, 1);
      chk($sformatf("t4_rgb_%0d", i), {red, green, blue}, {e, e, e});
      chk($sformatf("t4_done_%0d", i), frame_done, (i == NPIX - 2) ? 1 : 0);
    end
    pix_req = 1'b0;
    step();
    chk("t4_done_clear", frame_done, 0);
    repeat (20) step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("t4_underflow_cleared", underflow, 0);

    // reset mid-FETCH with 3 outstanding, stray returns afterwards
    for (int n = 0; n < 30 && q.size() < 3; n++) step();
    chk("t5_inflight", q.size(), 3);
    reset = 1'b1;
    #1;
    chk("t5_rst_rd_en", mem_rd_en, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_rgb", {red, green, blue}, 0);
    chk("t5_rst_valid", pix_valid, 0);
    chk("t5_rst_underflow", underflow, 0);
    chk("t5_rst_done", frame_done, 0);
    step();
    chk("t5_rst_hold_addr", mem_addr, 0);
    reset = 1'b0;
    for (int n = 0; n < 15; n++) begin
      pix_req = 1'b1;
      step();
      chk("t5_stray_valid", pix_valid, 0);
      chk("t5_stray_rd_en", mem_rd_en, 0);
      chk("t5_stray_underflow", underflow, 0);
    end
    pix_req = 1'b0;
    chk("t5_queue_drained", q.size(), 0);

    // fresh frame after reset starts cleanly at address 0
    lat = 1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (20) step();
    for (int i = 0; i < 3; i++) begin
      pix_req = 1'b1;
      step();
      e = img[i][7:4];
      chk($sformatf("t6_rgb_%0d", i), {red, green, blue}, {e, e, e});
      chk($sformatf("t6_valid_%0d", i), pix_valid, 1);
    end
    pix_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
